// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : multi-read-port register file with write bypass, port-1
//              write priority and a post-reset zeroing scrub.
// Revision   : 1.0
// ============================================================================
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int RET_REG  = 3,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  input  logic                   wen0,
  input  logic [AW-1:0]          waddr0,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic                   wen1,
  input  logic [AW-1:0]          waddr1,
  input  logic [WIDTH-1:0]       wdata1,
  output logic                   busy,
  output logic [WIDTH-1:0]       ret_val
);

  localparam logic [AW-1:0] RET_IDX   = AW'(RET_REG);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam bit            ZERO_EN   = (ZERO_REG != 0);
  localparam bit            BYPASS_EN = (BYPASS != 0);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    scrub_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] sel [NREAD];
  logic             we0;
  logic             we1;

  // Port 1 wins an address collision, so port 0 backs off when they match.
  assign we0 = wen0 && !(ZERO_EN && (waddr0 == '0)) && !(wen1 && (waddr1 == waddr0));
  assign we1 = wen1 && !(ZERO_EN && (waddr1 == '0));

  // The first edge out of reset already clears entry 0, so the scrub
  // takes exactly DEPTH edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      scrub_cnt <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_RESET, ST_CLEAR: begin
          mem[scrub_cnt] <= '0;
          scrub_cnt      <= scrub_cnt + AW'(1);
          if (scrub_cnt == LAST_IDX) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end else begin
            state <= ST_CLEAR;
          end
        end
        ST_READY: begin
          if (we0) mem[waddr0] <= wdata0;
          if (we1) mem[waddr1] <= wdata1;
        end
        default: begin
          state     <= ST_RESET;
          scrub_cnt <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

  generate
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = raddr[i*AW +: AW];
      assign sel[i] = (ZERO_EN && (ra == '0))                 ? '0     :
                      (BYPASS_EN && wen1 && (waddr1 == ra))   ? wdata1 :
                      (BYPASS_EN && wen0 && (waddr0 == ra))   ? wdata0 :
                                                                mem[ra];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || busy) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < NREAD; i++) begin
        rdata[i*WIDTH +: WIDTH] <= sel[i];
      end
    end
  end

  assign ret_val = busy ? '0 : mem[RET_IDX];

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_regfile_mp : scoreboard bench driving a bypass and a non-bypass instance
//                 with the same stimulus against an array reference model.
// Revision      : 1.0
// ============================================================================
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int RR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*W-1:0]  rdata_b, rdata_n;
  logic            wen0, wen1;
  logic [AW-1:0]   waddr0, waddr1;
  logic [W-1:0]    wdata0, wdata1;
  logic            busy_b, busy_n;
  logic [W-1:0]    ret_b, ret_n;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .BYPASS(1), .ZERO_REG(1), .RET_REG(RR)) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .busy(busy_b), .ret_val(ret_b));

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .BYPASS(0), .ZERO_REG(1), .RET_REG(RR)) dut_n (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .busy(busy_n), .ret_val(ret_n));

  typedef struct {
    logic [W-1:0] rb [NR];
    logic [W-1:0] rn [NR];
    logic         busy;
    logic [W-1:0] ret;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_mem [D];
  bit           model_ready = 1'b0;
  int           scrub_edges = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;

  task automatic check(input string name, input int lane, input int c,
                       input logic [W-1:0] got, input logic [W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s lane %0d cycle %0d: got %h, want %h", name, lane, c, got, want);
    end
  endtask

  // Monitor: every clock the DUTs present fresh outputs; compare to the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      for (int i = 0; i < NR; i++) begin
        check("rdata_bypass", i, e.cyc, rdata_b[i*W +: W], e.rb[i]);
        check("rdata_nobyp", i, e.cyc, rdata_n[i*W +: W], e.rn[i]);
      end
      check("busy_bypass", 0, e.cyc, {31'd0, busy_b}, {31'd0, e.busy});
      check("busy_nobyp", 0, e.cyc, {31'd0, busy_n}, {31'd0, e.busy});
      check("ret_bypass", 0, e.cyc, ret_b, e.ret);
      check("ret_nobyp", 0, e.cyc, ret_n, e.ret);
    end
  end

  // Apply one cycle of stimulus at the falling edge and predict the result of the next rising edge.
  task automatic drive(input bit rs, input bit w0, input int a0, input logic [W-1:0] d0,
                       input bit w1, input int a1, input logic [W-1:0] d1,
                       input int r0, input int r1, input int r2);
    exp_t e;
    int   ra [NR];
    @(negedge clk);
    rst_n = rs; wen0 = w0; waddr0 = AW'(a0); wdata0 = d0;
    wen1 = w1; waddr1 = AW'(a1); wdata1 = d1;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    raddr = {AW'(r2), AW'(r1), AW'(r0)};
    e.cyc = cyc++;
    for (int i = 0; i < NR; i++) begin
      e.rb[i] = '0;
      e.rn[i] = '0;
      if (rs && model_ready && ra[i] != 0) begin
        e.rn[i] = model_mem[ra[i]];
        if (w1 && a1 == ra[i])      e.rb[i] = d1;
        else if (w0 && a0 == ra[i]) e.rb[i] = d0;
        else                        e.rb[i] = model_mem[ra[i]];
      end
    end
    if (!rs) begin
      model_ready = 1'b0;
      scrub_edges = 0;
    end else if (!model_ready) begin
      scrub_edges++;
      if (scrub_edges == D) begin
        model_ready = 1'b1;
        for (int k = 0; k < D; k++) model_mem[k] = '0;
      end
    end else begin
      if (w0 && a0 != 0) model_mem[a0] = d0;
      if (w1 && a1 != 0) model_mem[a1] = d1;
    end
    e.busy = !model_ready;
    e.ret  = model_ready ? model_mem[RR] : '0;
    sb.push_back(e);
  endtask

  task automatic idle_read(input int r0, input int r1, input int r2);
    drive(1, 0, 0, 0, 0, 0, 0, r0, r1, r2);
  endtask

  task automatic rand_cycle(input bit rs);
    drive(rs, 1'($urandom), $urandom_range(0, 15), $urandom,
          1'($urandom), $urandom_range(0, 15), $urandom,
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31));
  endtask

  initial begin
    rst_n = 0; wen0 = 0; wen1 = 0; waddr0 = 0; waddr1 = 0;
    wdata0 = 0; wdata1 = 0; raddr = 0;
    for (int k = 0; k < D; k++) model_mem[k] = 'x;

    // Reset held for three cycles with junk writes that must be ignored.
    repeat (3) rand_cycle(0);
    // Scrub interrupted at count 10, then restarted in full.
    repeat (10) rand_cycle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < D; c++) begin
      if (c == 5) drive(1, 1, 3, 32'h77, 0, 0, 0, 3, 3, 3);
      else        rand_cycle(1);
    end
    // All entries read back zero after the scrub.
    for (int a = 0; a < D; a += NR) idle_read(a, (a + 1) % D, (a + 2) % D);

    // Write/read same edge, then read next edge.
    drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 5);
    idle_read(5, 5, 5);
    // Bypass on all lanes.
    drive(1, 1, 7, 32'h1234, 0, 0, 0, 7, 7, 7);
    idle_read(7, 7, 5);
    // Collision: port 1 wins, both for storage and bypass.
    drive(1, 1, 9, 32'hAAAA, 1, 9, 32'h5555, 9, 9, 9);
    idle_read(9, 9, 9);
    // Writes to r0 are dropped and r0 reads zero.
    drive(1, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0);
    idle_read(0, 0, 0);
    // Return register visible immediately after the write edge.
    drive(1, 1, 3, 32'h77, 0, 0, 0, 3, 0, 3);
    idle_read(3, 3, 3);

    repeat (300) rand_cycle(1);
    repeat (2) rand_cycle(0);
    repeat (D + 5) rand_cycle(1);
    repeat (200) rand_cycle(1);

    @(posedge clk); #2;
    @(posedge clk); #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the Dioptase pipelines, succeeding the fixed 32x32 two-read/two-write file. It adds the following:
- Configurable width, depth and read-port count.
- Optional same-cycle write-to-read bypass.
- Defined write-port collision priority.
- A post-reset scrub state machine that zeroes every entry before the pipeline may use the file.

It sits between decode (read addresses) and writeback (write port 0 for ALU/load results, write port 1 for pre/post-increment base updates).

## Interface
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 4; AW = $clog2(DEPTH).
- NREAD, 2, number of read ports, 1..8.
- BYPASS, 1, when 1 a read sees a same-cycle write to its address.
- ZERO_REG, 1, when 1 register 0 reads as zero and writes to it are discarded.
- RET_REG, 3, index exposed on ret_val (compiler return register).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- raddr  in  NREAD*AW  read addresses; port i is bits [i*AW +: AW].
- rdata  out  NREAD*WIDTH  registered read data; port i is bits [i*WIDTH +: WIDTH].
- wen0  in  1  write enable, port 0.
- waddr0  in  AW  write address, port 0.
- wdata0  in  WIDTH  write data, port 0.
- wen1  in  1  write enable, port 1.
- waddr1  in  AW  write address, port 1.
- wdata1  in  WIDTH  write data, port 1.
- busy  out  1  high while in reset or scrubbing; the pipeline must stall.
- ret_val  out  WIDTH  combinational view of register RET_REG.

## Operation
- FSM states:
  - RESET: entered whenever rst_n=0 is sampled. Scrub counter is set to 0.
  - CLEAR: entered on the first edge with rst_n=1. Each edge writes 0 to entry[counter] and increments the counter. At counter = DEPTH-1 that entry is written and the state moves to READY.
  - READY: normal operation.
- rst_n=0 sampled in any state, including mid-CLEAR, returns to RESET and restarts the scrub from 0.
- While busy=1 (RESET or CLEAR):
  - wen0 and wen1 are ignored.
  - Every rdata lane loads 0.
  - ret_val reads 0.
- READY writes:
  - Each enabled port writes its entry at the edge.
  - If both ports are enabled with waddr0 == waddr1, port 1 wins and port 0's data is dropped.
  - With ZERO_REG=1, a write to address 0 is discarded.
- READY reads: each lane i independently registers its selected value at every edge. No read enable; lanes are fully independent and may share addresses.
- Selected value, BYPASS=1, in priority order:
  - 0, when ZERO_REG=1 and the address is 0.
  - wdata1, when wen1 is set and waddr1 matches.
  - wdata0, when wen0 is set and waddr0 matches.
  - Otherwise the stored entry.
- Selected value, BYPASS=0: the stored entry, i.e. the pre-write value, with the same zero rule for address 0.
- ret_val: combinational read of the stored entry RET_REG, with no bypass; 0 while busy.
- Arithmetic: no computation on data. Addresses are always in range because DEPTH = 2^AW.

## Timing
- Read latency is 1 cycle: raddr sampled at edge N appears on rdata after edge N.
- A write at edge N is visible:
  - in storage and on ret_val after edge N;
  - to reads sampled at edge N+1 (non-bypass path);
  - to reads sampled at edge N itself when BYPASS=1.
- Reset values: rdata all 0, busy=1, ret_val=0.
- Scrub: busy stays high for exactly DEPTH cycles after the first edge with rst_n=1, and falls after the DEPTH-th such edge. Writes presented on the edge where busy falls are still ignored; the first accepted write is at the following edge.
- rdata holds its last value only by re-reading; it reloads every cycle.

## Test plan
- Reset release with DEPTH=32: hold rst_n=0 for 3 cycles, then release -> busy=1 for 32 cycles then 0; all 32 addresses subsequently read 0; ret_val=0.
- Write then read, BYPASS=0: write 0xDEADBEEF to r5 at edge N and read r5 at edge N -> old value 0. Read r5 at edge N+1 -> 0xDEADBEEF one cycle later.
- Bypass, BYPASS=1, NREAD=3: write 0x1234 to r7 and read r7 on all three lanes at the same edge -> all lanes show 0x1234 after that edge.
- Collision: wen0 with waddr0=9, wdata0=0xAAAA and wen1 with waddr1=9, wdata1=0x5555 -> r9 = 0x5555 and the bypassed read returns 0x5555. A write of 0xFFFF to r0 -> r0 reads 0.
- Mid-scrub reset: assert rst_n=0 at scrub count 10, then release -> busy is high for a full 32 cycles again. A write of 0x77 to r3 during the scrub is ignored and ret_val=0; after the scrub, writing 0x77 to r3 -> ret_val=0x77 on the same cycle as the edge.
